// File: rtl/ibus_mem_resp_pkg.sv
// Shared instruction-bus types and constants for the instruction memory responder.
// Optional overlap of accept and response is enabled with the IBUS_RESP_PIPE_EN macro.
package ibus_mem_resp_pkg;

  localparam logic [63:0] PCINIT   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } ibus_resp_state_t;

  // Picks the 32-bit instruction slot of a 64-bit memory word.
  function automatic logic [31:0] imem_half(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/ibus_mem_resp_if.sv
// Instruction-bus handshake bundle between the fetch stage (master) and the memory (slave).
interface ibus_mem_resp_if;
  import ibus_mem_resp_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input iresp);
  modport slave  (input ireq, output iresp);

endinterface

// File: rtl/ibus_mem_resp_imem_array.sv
// MEM_WORDS x 64 instruction storage: combinational read, synchronous backdoor write.
module imem_array #(
  parameter int unsigned MEM_WORDS = 4096,
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [63:0]      rd_data,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [63:0]      ld_data
);

  logic [63:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ibus_mem_resp.sv
// Instruction-bus responder: one outstanding fetch, fixed LATENCY, NOP+err on bad addresses.
// Define IBUS_RESP_PIPE_EN to let the RESP cycle also accept the next request.
module ibus_mem_resp
  import ibus_mem_resp_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = PCINIT,
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  ibus_mem_resp_if.slave   bus,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [63:0]      ld_data,
  output logic             err
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

`ifdef IBUS_RESP_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  ibus_resp_state_t state_reg;
  logic [63:0]      addr_reg;
  logic [3:0]       cnt_reg;
  logic             data_ok_reg;
  logic [31:0]      data_reg;
  logic             err_reg;

  logic             accept;
  logic             go_resp;
  logic [63:0]      addr_next;
  logic [60:0]      word_off;
  logic             out_of_range;
  logic [IDX_W-1:0] rd_idx;
  logic [63:0]      rd_data;
  logic [31:0]      fetch_data;
  logic             fetch_err;

  imem_array #(.MEM_WORDS(MEM_WORDS)) u_imem (
    .clk     (clk),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .ld_en   (ld_en),
    .ld_idx  (ld_idx),
    .ld_data (ld_data)
  );

  // The response word is looked up from the address that will be latched at this edge,
  // so a LATENCY==1 accept can go straight to RESP with correct data.
  always_comb begin
    accept       = bus.ireq.valid && ((state_reg == IDLE) || (PIPE_EN && (state_reg == RESP)));
    addr_next    = accept ? bus.ireq.addr : addr_reg;
    word_off     = addr_next[63:3] - BASE_ADDR[63:3];
    out_of_range = (addr_next < BASE_ADDR) || (word_off[60:IDX_W] != '0);
    rd_idx       = word_off[IDX_W-1:0];
    fetch_data   = out_of_range ? IMEM_NOP : imem_half(rd_data, addr_next[2]);
    fetch_err    = out_of_range || (addr_next[1:0] != 2'b00);
    if (accept) begin
      go_resp = (LATENCY == 1);
    end else begin
      go_resp = (state_reg == WAIT) && (cnt_reg == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      cnt_reg     <= '0;
      data_ok_reg <= 1'b0;
      data_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      data_ok_reg <= 1'b0;
      data_reg    <= '0;
      err_reg     <= 1'b0;
      if (accept) begin
        addr_reg <= bus.ireq.addr;
        cnt_reg  <= LAT_M1;
        state_reg <= WAIT;
      end else begin
        case (state_reg)
          WAIT:    cnt_reg <= cnt_reg - 4'd1;
          RESP:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
      if (go_resp) begin
        state_reg   <= RESP;
        data_ok_reg <= 1'b1;
        data_reg    <= fetch_data;
        err_reg     <= fetch_err;
      end
    end
  end

  assign bus.iresp = '{addr_ok: accept, data_ok: data_ok_reg, data: data_reg};
  assign err       = err_reg;

endmodule

// File: tb/tb_ibus_mem_resp.sv
// Directed bench for ibus_mem_resp (MEM_WORDS=4096, LATENCY=2); honours IBUS_RESP_PIPE_EN.
module tb_ibus_mem_resp;
  import ibus_mem_resp_pkg::*;

`ifdef IBUS_RESP_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  localparam logic [63:0] M0 = 64'h0010_0093_0000_0513;
  localparam logic [63:0] M1 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] M8 = 64'h1111_2222_3333_4444;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [11:0] ld_idx;
  logic [63:0] ld_data;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  ibus_mem_resp_if bus ();

  ibus_mem_resp #(.MEM_WORDS(4096), .LATENCY(2), .BASE_ADDR(64'h8000_0000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ld_en   (ld_en),
    .ld_idx  (ld_idx),
    .ld_data (ld_data),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
  endtask

  // Single isolated fetch: accept at T, data_ok at T+2, quiet at T+1 and T+3.
  task automatic fetch(input string tag, input logic [63:0] a, input logic [31:0] d, input logic e);
    bus.ireq.valid = 1'b1;
    bus.ireq.addr  = a;
    #1;
    chk({tag, "_addr_ok"}, 64'(bus.iresp.addr_ok), 64'd1);
    cyc();
    bus.ireq.valid = 1'b0;
    #1;
    chk({tag, "_wait_quiet"}, 64'(bus.iresp.data_ok), 64'd0);
    cyc();
    chk({tag, "_data_ok"}, 64'(bus.iresp.data_ok), 64'd1);
    chk({tag, "_data"}, 64'(bus.iresp.data), 64'(d));
    chk({tag, "_err"}, 64'(err), 64'(e));
    cyc();
    chk({tag, "_pulse_end"}, 64'(bus.iresp.data_ok), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [63:0] addrs [3];
    logic [31:0] datas [3];
    int dok [3];
    int aok [3];

    rst_n = 1'b0;
    ld_en = 1'b0;
    ld_idx = '0;
    ld_data = '0;
    bus.ireq.valid = 1'b0;
    bus.ireq.addr = '0;
    cyc();
    cyc();
    chk("rst_data_ok", 64'(bus.iresp.data_ok), 64'd0);
    chk("rst_data", 64'(bus.iresp.data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    ld_en = 1'b1; ld_idx = 12'd0; ld_data = M0;
    cyc();
    ld_idx = 12'd1; ld_data = M1;
    cyc();
    ld_idx = 12'd8; ld_data = M8;
    cyc();
    ld_en = 1'b0;
    chk("idle_addr_ok", 64'(bus.iresp.addr_ok), 64'd0);

    fetch("lo", 64'h8000_0000, 32'h0000_0513, 1'b0);
    fetch("hi", 64'h8000_0004, 32'h0010_0093, 1'b0);
    fetch("below", 64'h7FFF_FFFC, IMEM_NOP, 1'b1);
    fetch("above", 64'h8000_8000, IMEM_NOP, 1'b1);
    fetch("misal", 64'h8000_0002, 32'h0000_0513, 1'b1);
    fetch("misal_hi", 64'h8000_0006, 32'h0010_0093, 1'b1);

    // Valid held high across three fetches.
    addrs = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
    datas = '{32'h0000_0513, 32'h0010_0093, 32'hCCCC_DDDD};
    if (PIPE) begin
      dok = '{2, 4, 6};
      aok = '{0, 2, 4};
    end else begin
      dok = '{2, 5, 8};
      aok = '{0, 3, 6};
    end
    k = 0;
    for (int c = 0; c < 10; c++) begin
      int r;
      bus.ireq.valid = (k < 3);
      bus.ireq.addr  = (k < 3) ? addrs[k] : 64'h0;
      #1;
      chk($sformatf("b2b_addr_ok_c%0d", c), 64'(bus.iresp.addr_ok),
          64'((c == aok[0]) || (c == aok[1]) || (c == aok[2])));
      chk($sformatf("b2b_data_ok_c%0d", c), 64'(bus.iresp.data_ok),
          64'((c == dok[0]) || (c == dok[1]) || (c == dok[2])));
      r = (c == dok[0]) ? 0 : (c == dok[1]) ? 1 : (c == dok[2]) ? 2 : -1;
      if (r >= 0) begin
        chk($sformatf("b2b_data_c%0d", c), 64'(bus.iresp.data), 64'(datas[r]));
      end
      if (bus.iresp.addr_ok) k++;
      cyc();
    end
    bus.ireq.valid = 1'b0;
    cyc();

    // Flush: drop valid and change address while the first fetch is in flight.
    bus.ireq.valid = 1'b1; bus.ireq.addr = 64'h8000_0000;
    #1;
    chk("flush_accept", 64'(bus.iresp.addr_ok), 64'd1);
    cyc();
    bus.ireq.valid = 1'b0; bus.ireq.addr = 64'h8000_0040;
    #1;
    chk("flush_wait_addr_ok", 64'(bus.iresp.addr_ok), 64'd0);
    cyc();
    bus.ireq.valid = 1'b1;
    #1;
    chk("flush_data_ok", 64'(bus.iresp.data_ok), 64'd1);
    chk("flush_data", 64'(bus.iresp.data), 64'h0000_0513);
    chk("flush_resp_addr_ok", 64'(bus.iresp.addr_ok), 64'(PIPE));
    cyc();
    chk("flush_next_addr_ok", 64'(bus.iresp.addr_ok), 64'(!PIPE));
    chk("flush_single_pulse", 64'(bus.iresp.data_ok), 64'd0);
    cyc();
    bus.ireq.valid = 1'b0;
    #1;
    chk("flush_new_ok_a", 64'(bus.iresp.data_ok), 64'(PIPE));
    chk("flush_new_data_a", 64'(bus.iresp.data), PIPE ? 64'h3333_4444 : 64'h0);
    cyc();
    chk("flush_new_ok_b", 64'(bus.iresp.data_ok), 64'(!PIPE));
    chk("flush_new_data_b", 64'(bus.iresp.data), PIPE ? 64'h0 : 64'h3333_4444);
    cyc();
    cyc();

    // Reset during WAIT aborts the access silently.
    bus.ireq.valid = 1'b1; bus.ireq.addr = 64'h8000_0000;
    #1;
    chk("rstmid_accept", 64'(bus.iresp.addr_ok), 64'd1);
    cyc();
    bus.ireq.valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rstmid_data_ok", 64'(bus.iresp.data_ok), 64'd0);
    chk("rstmid_data", 64'(bus.iresp.data), 64'd0);
    chk("rstmid_err", 64'(err), 64'd0);
    chk("rstmid_addr_ok", 64'(bus.iresp.addr_ok), 64'd0);
    cyc();
    chk("rstmid_no_resp", 64'(bus.iresp.data_ok), 64'd0);
    fetch("post_rst", 64'h8000_0004, 32'h0010_0093, 1'b0);

    // Load to the fetched word in the RESP cycle: old data returned, new data next time.
    bus.ireq.valid = 1'b1; bus.ireq.addr = 64'h8000_0000;
    cyc();
    bus.ireq.valid = 1'b0;
    cyc();
    ld_en = 1'b1; ld_idx = 12'd0; ld_data = 64'h0010_0093_DEAD_BEEF;
    #1;
    chk("rbw_data_ok", 64'(bus.iresp.data_ok), 64'd1);
    chk("rbw_old_data", 64'(bus.iresp.data), 64'h0000_0513);
    cyc();
    ld_en = 1'b0;
    fetch("rbw_new", 64'h8000_0000, 32'hDEAD_BEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
